ibuf_read_ctrl: RTL and testbench
=================================

# ibuf_read_ctrl

Read-side controller for the three-bank ping-pong input buffer. It generates the shared bank read address, the A/B read enables, the 3×3 bank-rotation state and the bit-serial wait counter. The PE-side input buffer stage consumes these directly: it registers bank data into its three output columns when the read enable is high, the address is below `operator_length`, and `Bit_serial == Bit_serial_wait_counter`. The block sits between the layer sequencer (which sends `start`) and the input buffer BRAM banks plus the PE-side buffer stage.

## Interface
- `OFF_TO_ON_ADDRESS_SIZE`, 13, width of on-chip buffer addresses and lengths
- `clk`  in  1  clock
- `rst_n`  in  1  synchronous active-low reset
- `start`  in  1  one-cycle pulse that launches a pass; ignored while `busy`
- `buf_sel`  in  1  ping-pong side, 0 = A, 1 = B; sampled on accepted `start`
- `Kernel_Size`  in  2  3 enables bank rotation; any other value holds `state` at 0; sampled on `start`
- `Bit_serial`  in  4  last bit-serial cycle index per word (0..15); sampled on `start`
- `operator_length`  in  13  words per row pass; sampled on `start`
- `row_count`  in  13  row passes per job; sampled on `start`
- `pe_stall`  in  1  freezes all counters and outputs while high
- `On_to_PE_addr`  out  13  read address shared by banks 0/1/2
- `state`  out  2  bank rotation: 00, 01 or 10; never 11
- `ibuf_rd_A`  out  1  reading side A
- `ibuf_rd_B`  out  1  reading side B
- `Bit_serial_wait_counter`  out  4  cycle index within the current word
- `busy`  out  1  a pass is in progress
- `done`  out  1  one-cycle pulse when the job completes

## Operation
- FSM states: IDLE, READ, ROW_END, DONE.
- IDLE: all outputs 0. On `start`, latch the configuration inputs.
  - If `operator_length == 0` or `row_count == 0`, go to DONE. No read enable is asserted.
  - Otherwise go to READ with addr = 0, wait counter = 0, row index = 0, `state` = 00.
- READ:
  - `ibuf_rd_A = ~sel`, `ibuf_rd_B = sel`. Exactly one is high, never both.
  - The wait counter increments each cycle.
  - When the counter equals latched `Bit_serial`, it resets to 0 and addr increments.
  - If that happens with addr == `operator_length`−1, go to ROW_END instead of incrementing addr.
- ROW_END: a one-cycle bubble.
  - Read enables 0, addr = 0, counter = 0.
  - Row index increments.
  - If latched Kernel_Size == 3, `state` rotates 00→01→10→00. Otherwise it stays 00.
  - If row index + 1 == `row_count`, go to DONE; else go to READ.
- DONE: `done` = 1 for one cycle, `busy` = 0, then IDLE.
- `busy` = 1 in READ and ROW_END only.
- `pe_stall` = 1 in READ or ROW_END: no state, counter, addr or row change, and outputs hold. Ignored in IDLE and DONE.
- `start` during `busy` or DONE is dropped, with no side effects.
- Addr never reaches `operator_length` while a read enable is high.
- Row index is 13 bits and never wraps, because it is bounded by `row_count`.

## Timing
- Reset (`rst_n` = 0 at a clk edge) forces IDLE, including mid-pass.
- All outputs reset to 0: `On_to_PE_addr`, `state`, `ibuf_rd_A/B`, `Bit_serial_wait_counter`, `busy`, `done`.
- All outputs are registered. A `start` sampled at edge T gives `busy` = 1, read enable = 1 and addr = 0 after edge T+1.
- Each word is presented for `Bit_serial`+1 cycles.
- One row pass takes `operator_length`×(`Bit_serial`+1) READ cycles plus 1 ROW_END cycle.
- `done` rises the cycle after the final ROW_END.
- Total job length from `start` to `done`: `row_count`×(`operator_length`×(`Bit_serial`+1)+1)+1 cycles, excluding stall cycles.
- BRAM read latency (1 cycle) is absorbed downstream. This block does not delay `state`.

## Test plan
- **Basic pass, no rotation:** reset, then `start` with buf_sel=0, Kernel_Size=1, Bit_serial=0, operator_length=4, row_count=1.
  - Expect `ibuf_rd_A` high for 4 cycles with addr 0,1,2,3, `ibuf_rd_B` = 0, `state` = 00.
  - Expect one ROW_END bubble, then `done` 6 cycles after `start`.
- **Bit-serial hold and rotation:** buf_sel=1, Kernel_Size=3, Bit_serial=2, operator_length=2, row_count=4.
  - Each addr is held 3 cycles while the counter steps 0,1,2.
  - `state` sequence across rows: 00,01,10,00.
  - `done` arrives at cycle 4×(6+1)+1 = 29.
- **Zero length:** `start` with operator_length=0, and separately with row_count=0.
  - Expect no read enable, `busy` never high, `done` one cycle after `start`.
- **Stall and dropped start:** assert `pe_stall` for 5 cycles mid-row at addr 3, counter 1.
  - Outputs must hold exactly, and the job finishes 5 cycles later than unstalled.
  - Pulse `start` while `busy`; the job must be unaffected.
- **Reset mid-operation:** drop `rst_n` during READ with addr 7 and `state` 01.
  - Next cycle all outputs are 0 and the FSM is in IDLE.
  - A new `start` then runs normally from addr 0, `state` 00.
- **Max config:** Bit_serial=15, operator_length=8191, row_count=2.
  - Addr reaches 8190, never 8191, with no wrap.
  - `done` arrives at cycle 2×(8191×16+1)+1.

Source files
------------

// File: rtl/ibuf_read_ctrl.sv
// Read-side controller for the three-bank ping-pong input buffer: shared bank address,
// A/B read enables, 3x3 bank rotation state and the bit-serial wait counter.
module ibuf_read_ctrl #(
    parameter int OFF_TO_ON_ADDRESS_SIZE = 13
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              buf_sel,
    input  logic [1:0]                        Kernel_Size,
    input  logic [3:0]                        Bit_serial,
    input  logic [OFF_TO_ON_ADDRESS_SIZE-1:0] operator_length,
    input  logic [OFF_TO_ON_ADDRESS_SIZE-1:0] row_count,
    input  logic                              pe_stall,
    output logic [OFF_TO_ON_ADDRESS_SIZE-1:0] On_to_PE_addr,
    output logic [1:0]                        state,
    output logic                              ibuf_rd_A,
    output logic                              ibuf_rd_B,
    output logic [3:0]                        Bit_serial_wait_counter,
    output logic                              busy,
    output logic                              done
);
    localparam int AW = OFF_TO_ON_ADDRESS_SIZE;

    typedef enum logic [1:0] {IDLE, READ, ROW_END, DONE} fsm_t;

    fsm_t          fsm_q;
    logic          sel_q;
    logic          rot_en_q;
    logic [3:0]    bs_q;
    logic [AW-1:0] len_q;
    logic [AW-1:0] rows_q;
    logic [AW-1:0] row_idx_q;
    logic [AW-1:0] addr_q;
    logic [3:0]    cnt_q;
    logic [1:0]    rot_q;
    logic          rd_a_q;
    logic          rd_b_q;
    logic          busy_q;
    logic          done_q;

    // Outputs are computed alongside the next FSM state so they line up with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q     <= IDLE;
            sel_q     <= 1'b0;
            rot_en_q  <= 1'b0;
            bs_q      <= '0;
            len_q     <= '0;
            rows_q    <= '0;
            row_idx_q <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            rot_q     <= '0;
            rd_a_q    <= 1'b0;
            rd_b_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        sel_q     <= buf_sel;
                        rot_en_q  <= (Kernel_Size == 2'd3);
                        bs_q      <= Bit_serial;
                        len_q     <= operator_length;
                        rows_q    <= row_count;
                        row_idx_q <= '0;
                        addr_q    <= '0;
                        cnt_q     <= '0;
                        rot_q     <= '0;
                        if (operator_length == '0 || row_count == '0) begin
                            fsm_q  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            fsm_q  <= READ;
                            busy_q <= 1'b1;
                            rd_a_q <= ~buf_sel;
                            rd_b_q <= buf_sel;
                        end
                    end
                end
                READ: begin
                    if (!pe_stall) begin
                        if (cnt_q == bs_q) begin
                            cnt_q <= '0;
                            if (addr_q == len_q - AW'(1)) begin
                                fsm_q  <= ROW_END;
                                addr_q <= '0;
                                rd_a_q <= 1'b0;
                                rd_b_q <= 1'b0;
                            end else begin
                                addr_q <= addr_q + AW'(1);
                            end
                        end else begin
                            cnt_q <= cnt_q + 4'd1;
                        end
                    end
                end
                ROW_END: begin
                    if (!pe_stall) begin
                        row_idx_q <= row_idx_q + AW'(1);
                        if (row_idx_q + AW'(1) == rows_q) begin
                            fsm_q  <= DONE;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
                            rot_q  <= '0;
                        end else begin
                            fsm_q  <= READ;
                            rd_a_q <= ~sel_q;
                            rd_b_q <= sel_q;
                            if (rot_en_q)
                                rot_q <= (rot_q == 2'd2) ? 2'd0 : rot_q + 2'd1;
                        end
                    end
                end
                default: begin
                    // DONE: single-cycle pulse, any start here is dropped
                    fsm_q  <= IDLE;
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    rot_q  <= '0;
                end
            endcase
        end
    end

    assign On_to_PE_addr           = addr_q;
    assign state                   = rot_q;
    assign ibuf_rd_A               = rd_a_q;
    assign ibuf_rd_B               = rd_b_q;
    assign Bit_serial_wait_counter = cnt_q;
    assign busy                    = busy_q;
    assign done                    = done_q;

endmodule

// File: tb/tb_ibuf_read_ctrl.sv
// Bench for ibuf_read_ctrl: expected per-cycle output traces are generated from the
// job parameters (rows x words x bit cycles) and compared cycle by cycle.
module tb_ibuf_read_ctrl;
    localparam int AW = 13;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          buf_sel = 1'b0;
    logic [1:0]    Kernel_Size = '0;
    logic [3:0]    Bit_serial = '0;
    logic [AW-1:0] operator_length = '0;
    logic [AW-1:0] row_count = '0;
    logic          pe_stall = 1'b0;
    logic [AW-1:0] On_to_PE_addr;
    logic [1:0]    state;
    logic          ibuf_rd_A;
    logic          ibuf_rd_B;
    logic [3:0]    Bit_serial_wait_counter;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [1:0]    st;
        logic          rda;
        logic          rdb;
        logic [3:0]    cnt;
        logic          busy;
        logic          done;
    } obs_t;

    obs_t exp_q[$];
    obs_t obs;

    ibuf_read_ctrl #(.OFF_TO_ON_ADDRESS_SIZE(AW)) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .start                   (start),
        .buf_sel                 (buf_sel),
        .Kernel_Size             (Kernel_Size),
        .Bit_serial              (Bit_serial),
        .operator_length         (operator_length),
        .row_count               (row_count),
        .pe_stall                (pe_stall),
        .On_to_PE_addr           (On_to_PE_addr),
        .state                   (state),
        .ibuf_rd_A               (ibuf_rd_A),
        .ibuf_rd_B               (ibuf_rd_B),
        .Bit_serial_wait_counter (Bit_serial_wait_counter),
        .busy                    (busy),
        .done                    (done)
    );

    always #5 clk = ~clk;

    assign obs = {On_to_PE_addr, state, ibuf_rd_A, ibuf_rd_B, Bit_serial_wait_counter, busy, done};

    task automatic check(input obs_t e, input string tag, input int cyc);
        n_cmp++;
        assert (obs === e) else begin
            n_err++;
            $error("FAIL %s cyc=%0d: observed addr=%0d st=%0d rdA=%0b rdB=%0b cnt=%0d busy=%0b done=%0b, expected addr=%0d st=%0d rdA=%0b rdB=%0b cnt=%0d busy=%0b done=%0b",
                   tag, cyc, obs.addr, obs.st, obs.rda, obs.rdb, obs.cnt, obs.busy, obs.done,
                   e.addr, e.st, e.rda, e.rdb, e.cnt, e.busy, e.done);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int want);
        n_cmp++;
        assert (got == want) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, got, want);
        end
    endtask

    // Expected trace: every word held bs+1 cycles, one bubble per row, then a done pulse.
    task automatic build(input logic bsel, input logic [1:0] ks, input int bs, input int len, input int rows);
        obs_t e;
        exp_q.delete();
        if (len != 0 && rows != 0) begin
            for (int r = 0; r < rows; r++) begin
                for (int w = 0; w < len; w++) begin
                    for (int c = 0; c <= bs; c++) begin
                        e      = '0;
                        e.addr = AW'(w);
                        e.st   = (ks == 2'd3) ? 2'(r % 3) : 2'd0;
                        e.rda  = ~bsel;
                        e.rdb  = bsel;
                        e.cnt  = 4'(c);
                        e.busy = 1'b1;
                        exp_q.push_back(e);
                    end
                end
                e      = '0;
                e.st   = (ks == 2'd3) ? 2'(r % 3) : 2'd0;
                e.busy = 1'b1;
                exp_q.push_back(e);
            end
        end
        e      = '0;
        e.done = 1'b1;
        exp_q.push_back(e);
    endtask

    task automatic run_job(input logic bsel, input logic [1:0] ks, input int bs, input int len,
                           input int rows, input int stall_at, input int stall_len,
                           input bit rand_stall, input int extra_start_at, input int abort_at,
                           input string name);
        int idx = 0;
        int cyc = 0;
        int stalls = 0;
        int done_cyc = -1;
        int want_len;
        bit aborted = 0;
        logic [31:0] r;
        build(bsel, ks, bs, len, rows);
        want_len = (len == 0 || rows == 0) ? 1 : rows * (len * (bs + 1) + 1) + 1;
        buf_sel         = bsel;
        Kernel_Size     = ks;
        Bit_serial      = 4'(bs);
        operator_length = AW'(len);
        row_count       = AW'(rows);
        pe_stall        = 1'b0;
        start           = 1'b1;
        @(posedge clk); #1;
        cyc = 1;
        while (idx < exp_q.size()) begin
            check(exp_q[idx], name, cyc);
            if (exp_q[idx].done) done_cyc = cyc;
            if (cyc == abort_at) begin
                rst_n    = 1'b0;
                start    = 1'b0;
                pe_stall = 1'b0;
                @(posedge clk); #1;
                rst_n = 1'b1;
                check('0, {name, "_reset"}, cyc + 1);
                aborted = 1;
                break;
            end
            if (rand_stall)
                pe_stall = ($urandom_range(0, 5) == 0);
            else
                pe_stall = (cyc >= stall_at && cyc < stall_at + stall_len);
            start = (cyc == extra_start_at);
            // configuration inputs must only matter on the accepted start
            r               = $urandom;
            buf_sel         = r[0];
            Kernel_Size     = r[2:1];
            Bit_serial      = r[6:3];
            operator_length = r[19:7];
            row_count       = r[31:19];
            if (pe_stall && exp_q[idx].busy) stalls++;
            else idx++;
            @(posedge clk); #1;
            cyc++;
        end
        start    = 1'b0;
        pe_stall = 1'b0;
        if (!aborted) begin
            check('0, {name, "_idle"}, cyc);
            check_int({name, "_done_cycle"}, done_cyc, want_len + stalls);
        end
        $display("job %s: bsel=%0b ks=%0d bs=%0d len=%0d rows=%0d stalls=%0d done_cyc=%0d aborted=%0b",
                 name, bsel, ks, bs, len, rows, stalls, done_cyc, aborted);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check('0, "reset", 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check('0, "idle_after_reset", 0);

        run_job(1'b0, 2'd1, 0, 4, 1, -1, 0, 1'b0, -1, -1, "basic");
        run_job(1'b1, 2'd3, 2, 2, 4, -1, 0, 1'b0, -1, -1, "rotate");
        run_job(1'b0, 2'd3, 1, 0, 3, -1, 0, 1'b0, -1, -1, "zero_len");
        run_job(1'b1, 2'd1, 1, 5, 0, -1, 0, 1'b0, -1, -1, "zero_rows");
        // stall 5 cycles while addr 3 / counter 1 is shown, then a start while busy
        run_job(1'b0, 2'd3, 2, 6, 2, 11, 5, 1'b0, 20, -1, "stall_drop");
        // reset on the cycle showing row 1, addr 7, state 01
        run_job(1'b1, 2'd3, 0, 10, 3, -1, 0, 1'b0, -1, 19, "reset_mid");
        run_job(1'b0, 2'd3, 0, 3, 2, -1, 0, 1'b0, -1, -1, "after_reset");

        for (int j = 0; j < 8; j++) begin
            run_job(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom_range(0, 4),
                    $urandom_range(1, 9), $urandom_range(1, 5), -1, 0, 1'b1,
                    $urandom_range(2, 12), -1, "random");
        end

        run_job(1'b1, 2'd2, 15, 3, 2, -1, 0, 1'b0, -1, -1, "bs15");
        run_job(1'b0, 2'd3, 2, 8191, 2, -1, 0, 1'b0, -1, -1, "max_len");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
